serial_adder: RTL
=================

// Module: serial_adder
//
// PURPOSE
//  Bit-serial WIDTH-bit adder. Loads two operands on a start strobe and adds them LSB-first,
//  one bit per clock, through a single full_adder_cell built from two half_adder instances.
//  A registered carry links the bits. Sits downstream of the half_adder cell as its first
//  sequential consumer. Area-cheap arithmetic for control/datapath blocks where latency is
//  acceptable.
//
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range >= 2
//  CNT_W   $clog2(WIDTH+1)   bit-counter width; derived localparam, not overridable
//
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst_n      in   1      asynchronous active-low reset; deassertion synchronised externally
//  start      in   1      request; sampled only in IDLE or DONE
//  a          in   WIDTH  operand A, captured on accepted start
//  b          in   WIDTH  operand B, captured on accepted start
//  sub        in   1      subtract request, captured with operands (only with SERIAL_ADDER_SUB_EN)
//  busy       out  1      high while in RUN
//  done       out  1      one-cycle pulse: result valid
//  sum        out  WIDTH  result, held from done until next accepted start
//  carry      out  1      final carry-out, held with sum
//
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - state=IDLE; a_sh, b_sh, sum, cnt all 0.
//    - carry_r=0, carry=0, busy=0, done=0.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: start=1 -> capture a into a_sh and b into b_sh; carry_r=0; cnt=0; go to RUN.
//    - RUN: each edge:
//      - s,c = full_adder_cell(a_sh[0], b_sh[0], carry_r).
//      - sum shifts right with s entering bit WIDTH-1.
//      - a_sh and b_sh shift right; carry_r=c; cnt++.
//      - On the edge where cnt==WIDTH-1: go to DONE, done=1, carry=c.
//    - DONE: lasts exactly one cycle.
//      - start=1 -> re-capture and go to RUN (back-to-back, no bubble).
//      - Otherwise go to IDLE.
//  - Latency: start accepted on edge E0 -> done high in the cycle after edge E_WIDTH.
//    Throughput is one operation per WIDTH+1 cycles.
//  - start while in RUN is ignored; operands are not re-sampled.
//  - a and b may change freely after the start edge.
//  - Arithmetic: {carry,sum} = a + b, modulo 2^(WIDTH+1); no overflow flag.
//  - sum and carry are not cleared on returning to IDLE.
//    - They update bit-by-bit during RUN (intermediate values are not valid).
//  - Reset mid-operation aborts immediately to the reset values; there is no partial done.
//  - busy = (state==RUN); done = (state==DONE); both decoded from the registered state.
//
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined:
//   - sub port exists and is captured on start.
//   - If sub=1: b_sh loads ~b and carry_r initialises to 1, so sum = a - b.
//   - carry=1 means no borrow (a >= b unsigned).
//  SERIAL_ADDER_SUB_EN undefined:
//   - sub port is absent.
//   - Add only; carry_r always initialises to 0.
//
// STRUCTURE
//  - serial_adder_pkg:
//    - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//    - WIDTH_DEFAULT = 8.
//  - Sub-module full_adder_cell(a, b, cin -> sum, cout):
//    - two half_adder instances plus an OR of their carries.
//    - purely combinational; instantiated once.
//
// TESTING  (WIDTH=8)
//  - Reset: rst_n=0 -> busy=0, done=0, sum=0x00, carry=0.
//  - 0x5A + 0x3C, start held for 1 cycle:
//    - busy high for 8 cycles, then done pulses for 1 cycle.
//    - sum=0x96, carry=0.
//  - 0xFF + 0x01 -> sum=0x00, carry=1; 0x00 + 0x00 -> sum=0x00, carry=0.
//  - Pulse start with 0x11+0x22 in the 3rd RUN cycle of an operation on 0x01+0x01:
//    - the extra start is ignored.
//    - result is sum=0x02, carry=0; exactly one done pulse.
//  - Drop rst_n at the 4th RUN cycle:
//    - all outputs return to reset values immediately.
//    - no done pulse; a new start works normally.
//  - start held high through DONE with 0x80+0x80:
//    - second operation begins with no IDLE cycle.
//    - done pulses every 9 cycles; sum=0x00, carry=1.
//  - (SERIAL_ADDER_SUB_EN) 0x10 - 0x01 -> sum=0x0F, carry=1.
//  - (SERIAL_ADDER_SUB_EN) 0x01 - 0x02 -> sum=0xFF, carry=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   state_t       : controller states (IDLE, RUN, DONE)
//   WIDTH_DEFAULT : default operand width
package serial_adder_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell
//   Combinational full adder built from two half adders.
//   a, b, cin : operand bits and carry in
//   sum, cout : sum bit and carry out
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a    (a),
      .b    (b),
      .sum  (s0),
      .cout (c0)
   );

   half_adder u_ha1 (
      .a    (s0),
      .b    (cin),
      .sum  (sum),
      .cout (c1)
   );

   // Both half-adder carries can never be high together, so OR is exact.
   assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// half_adder
//   Single-bit half adder.
//   a, b  : operand bits
//   sum   : a xor b
//   cout  : a and b
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b;
   assign cout = a & b;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder: operands are captured on an accepted start and
//   added LSB-first, one bit per clock, through a single full_adder_cell.
//   Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port; sub=1
//   computes a - b, carry=1 meaning no borrow).
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     start      : request, honoured only in IDLE or DONE
//     a, b       : operands, captured on accepted start
//     sub        : subtract request (SERIAL_ADDER_SUB_EN only)
//     busy       : high while the operation is running
//     done       : one-cycle result-valid pulse
//     sum, carry : result and final carry-out, held until the next start
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry_r;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] b_load;
   logic             cin_load;
   logic             fa_s;
   logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: add ~b with an initial carry of 1.
   assign b_load   = sub ? ~b : b;
   assign cin_load = sub;
`else
   assign b_load   = b;
   assign cin_load = 1'b0;
`endif

   full_adder_cell u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_r),
      .sum  (fa_s),
      .cout (fa_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         sum     <= '0;
         cnt     <= '0;
         carry_r <= 1'b0;
         carry   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b_load;
                  carry_r <= cin_load;
                  cnt     <= '0;
                  state   <= RUN;
               end else begin
                  state   <= IDLE;
               end
            end
            RUN: begin
               sum     <= {fa_s, sum[WIDTH-1:1]};
               a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
               carry_r <= fa_c;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  carry <= fa_c;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
